// File: rtl/ao486_l15_req_arbiter_if.sv
// Bundle of the memory requester, I/O requester and L1.5 transducer signals
// seen by the ao486 L1.5 request arbiter.
interface ao486_l15_req_arbiter_if;
    // Request ports: a transfer happens in any cycle where *_req_val and
    // *_req_rdy are both high. rdy never depends on a later val. *_rsp_val
    // is a one-cycle pulse with no back-pressure.
    logic        mem_req_val;
    logic        mem_req_we;
    logic [39:0] mem_req_addr;
    logic [63:0] mem_req_data;
    logic [2:0]  mem_req_size;
    logic        mem_req_nc;
    logic        mem_req_rdy;
    logic        mem_rsp_val;
    logic [63:0] mem_rsp_data;

    logic        io_req_val;
    logic        io_req_we;
    logic [15:0] io_req_addr;
    logic [31:0] io_req_data;
    logic [2:0]  io_req_size;
    logic        io_req_rdy;
    logic        io_rsp_val;
    logic [31:0] io_rsp_data;

    logic        transducer_l15_val;
    logic [4:0]  transducer_l15_rqtype;
    logic [2:0]  transducer_l15_size;
    logic [39:0] transducer_l15_address;
    logic [63:0] transducer_l15_data;
    logic        transducer_l15_nc;
    logic        l15_transducer_ack;
    logic        l15_transducer_val;
    logic [3:0]  l15_transducer_returntype;
    logic [63:0] l15_transducer_data_0;
    logic        transducer_l15_req_ack;

    modport slave (
        input  mem_req_val, mem_req_we, mem_req_addr, mem_req_data, mem_req_size, mem_req_nc,
        output mem_req_rdy, mem_rsp_val, mem_rsp_data,
        input  io_req_val, io_req_we, io_req_addr, io_req_data, io_req_size,
        output io_req_rdy, io_rsp_val, io_rsp_data,
        output transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
        output transducer_l15_address, transducer_l15_data, transducer_l15_nc,
        input  l15_transducer_ack, l15_transducer_val, l15_transducer_returntype,
        input  l15_transducer_data_0,
        output transducer_l15_req_ack
    );

    modport master (
        output mem_req_val, mem_req_we, mem_req_addr, mem_req_data, mem_req_size, mem_req_nc,
        input  mem_req_rdy, mem_rsp_val, mem_rsp_data,
        output io_req_val, io_req_we, io_req_addr, io_req_data, io_req_size,
        input  io_req_rdy, io_rsp_val, io_rsp_data,
        input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
        input  transducer_l15_address, transducer_l15_data, transducer_l15_nc,
        output l15_transducer_ack, l15_transducer_val, l15_transducer_returntype,
        output l15_transducer_data_0,
        input  transducer_l15_req_ack
    );
endinterface

// File: rtl/ao486_l15_req_arbiter.sv
// Round-robin sharing of the single L1.5 port between the ao486 memory and
// I/O requesters, one transaction in flight, with a WAIT watchdog.
module ao486_l15_req_arbiter #(
    parameter logic [39:0] IO_BASE = 40'hF0_0000_0000,
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    ao486_l15_req_arbiter_if.slave    bus,
    output logic                      err_timeout,
    output logic [1:0]                state_dbg
);
    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] STORE_RQ = 5'b00001;
    localparam logic [3:0] LOAD_RET = 4'b0000;
    localparam logic [3:0] ST_ACK   = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_MEM = 1'b0,
        OWN_IO  = 1'b1
    } owner_t;

    state_t      state;
    owner_t      last_grant;
    owner_t      owner;
    logic        r_we;
    logic        r_io_hi;
    logic [15:0] wd_cnt;

    logic        grant_mem;
    logic        grant_io;
    logic        in_idle;
    logic        ret_type_ok;
    logic        ret_match;
    logic        timeout_hit;
    logic        done;
    logic [63:0] rsp_word;

    assign state_dbg = state;

    // On a tie the requester that did not win last time is granted.
    assign grant_mem = bus.mem_req_val && (!bus.io_req_val || last_grant == OWN_IO);
    assign grant_io  = bus.io_req_val && (!bus.mem_req_val || last_grant == OWN_MEM);
    assign in_idle   = (state == S_IDLE) && !rst;

    assign bus.mem_req_rdy = in_idle && grant_mem;
    assign bus.io_req_rdy  = in_idle && grant_io;

    assign ret_type_ok = r_we ? (bus.l15_transducer_returntype == ST_ACK)
                              : (bus.l15_transducer_returntype == LOAD_RET);

    // A return completes the transaction in WAIT, or in ISSUE when it rides
    // along with the ack; anything else is consumed and dropped.
    assign ret_match = !rst && bus.l15_transducer_val && ret_type_ok &&
                       ((state == S_WAIT) || (state == S_ISSUE && bus.l15_transducer_ack));
    assign timeout_hit = !rst && (state == S_WAIT) && !ret_match &&
                         (wd_cnt == TIMEOUT - 16'd1);
    assign done = ret_match || timeout_hit;

    assign bus.transducer_l15_req_ack = !rst && bus.l15_transducer_val;

    assign rsp_word = timeout_hit ? {64{1'b1}} :
                      (r_we ? 64'd0 : bus.l15_transducer_data_0);

    assign bus.mem_rsp_val  = done && (owner == OWN_MEM);
    assign bus.io_rsp_val   = done && (owner == OWN_IO);
    assign bus.mem_rsp_data = bus.mem_rsp_val ? rsp_word : 64'd0;
    assign bus.io_rsp_data  = !bus.io_rsp_val ? 32'd0 :
                              (r_io_hi ? rsp_word[31:0] : rsp_word[63:32]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                      <= S_IDLE;
            last_grant                 <= OWN_IO;
            owner                      <= OWN_MEM;
            r_we                       <= 1'b0;
            r_io_hi                    <= 1'b0;
            wd_cnt                     <= 16'd0;
            err_timeout                <= 1'b0;
            bus.transducer_l15_val     <= 1'b0;
            bus.transducer_l15_rqtype  <= 5'd0;
            bus.transducer_l15_size    <= 3'd0;
            bus.transducer_l15_address <= 40'd0;
            bus.transducer_l15_data    <= 64'd0;
            bus.transducer_l15_nc      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.mem_req_val && bus.mem_req_rdy) begin
                        state                      <= S_ISSUE;
                        last_grant                 <= OWN_MEM;
                        owner                      <= OWN_MEM;
                        r_we                       <= bus.mem_req_we;
                        r_io_hi                    <= 1'b0;
                        bus.transducer_l15_val     <= 1'b1;
                        bus.transducer_l15_rqtype  <= bus.mem_req_we ? STORE_RQ : LOAD_RQ;
                        bus.transducer_l15_size    <= bus.mem_req_size;
                        bus.transducer_l15_address <= bus.mem_req_addr;
                        bus.transducer_l15_data    <= bus.mem_req_data;
                        bus.transducer_l15_nc      <= bus.mem_req_nc;
                    end else if (bus.io_req_val && bus.io_req_rdy) begin
                        state                      <= S_ISSUE;
                        last_grant                 <= OWN_IO;
                        owner                      <= OWN_IO;
                        r_we                       <= bus.io_req_we;
                        r_io_hi                    <= bus.io_req_addr[2];
                        bus.transducer_l15_val     <= 1'b1;
                        bus.transducer_l15_rqtype  <= bus.io_req_we ? STORE_RQ : LOAD_RQ;
                        bus.transducer_l15_size    <= bus.io_req_size;
                        bus.transducer_l15_address <= {IO_BASE[39:16], bus.io_req_addr};
                        bus.transducer_l15_data    <= {bus.io_req_data, bus.io_req_data};
                        bus.transducer_l15_nc      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.l15_transducer_ack) begin
                        bus.transducer_l15_val <= 1'b0;
                        wd_cnt                 <= 16'd0;
                        state                  <= ret_match ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ret_match) begin
                        state <= S_IDLE;
                    end else if (timeout_hit) begin
                        state       <= S_IDLE;
                        err_timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ao486_l15_req_arbiter.sv
// Directed bench for ao486_l15_req_arbiter; inputs change on the falling
// edge and outputs are sampled 1 time unit later.
module tb_ao486_l15_req_arbiter;
    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] STORE_RQ = 5'b00001;
    localparam logic [3:0] LOAD_RET = 4'b0000;
    localparam logic [3:0] ST_ACK   = 4'b0100;
    localparam logic [3:0] INT_RET  = 4'b0111;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic       clk;
    logic       rst;
    logic       err_timeout;
    logic [1:0] state_dbg;
    int         n_checks;
    int         n_errors;
    logic [0:0] exp_q[$];

    ao486_l15_req_arbiter_if bus ();

    ao486_l15_req_arbiter #(
        .IO_BASE (40'hF0_0000_0000),
        .TIMEOUT (16'd16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .err_timeout (err_timeout),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs;
        bus.mem_req_val = 1'b0; bus.mem_req_we = 1'b0; bus.mem_req_addr = 40'd0;
        bus.mem_req_data = 64'd0; bus.mem_req_size = 3'd0; bus.mem_req_nc = 1'b0;
        bus.io_req_val = 1'b0; bus.io_req_we = 1'b0; bus.io_req_addr = 16'd0;
        bus.io_req_data = 32'd0; bus.io_req_size = 3'd0;
        bus.l15_transducer_ack = 1'b0; bus.l15_transducer_val = 1'b0;
        bus.l15_transducer_returntype = 4'd0; bus.l15_transducer_data_0 = 64'd0;
    endtask

    task automatic drive_mem(input logic we, input logic [39:0] addr, input logic [63:0] data,
                             input logic [2:0] size, input logic nc);
        bus.mem_req_val = 1'b1; bus.mem_req_we = we; bus.mem_req_addr = addr;
        bus.mem_req_data = data; bus.mem_req_size = size; bus.mem_req_nc = nc;
    endtask

    task automatic drive_io(input logic we, input logic [15:0] addr, input logic [31:0] data,
                            input logic [2:0] size);
        bus.io_req_val = 1'b1; bus.io_req_we = we; bus.io_req_addr = addr;
        bus.io_req_data = data; bus.io_req_size = size;
    endtask

    task automatic drive_ret(input logic [3:0] rtype, input logic [63:0] data);
        bus.l15_transducer_val = 1'b1; bus.l15_transducer_returntype = rtype;
        bus.l15_transducer_data_0 = data;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        bus.mem_req_val = 1'b1;
        bus.l15_transducer_val = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.mem_req_rdy !== 1'b0) begin n_errors++; $display("FAIL reset_mem_rdy: got %0h, expected 0", bus.mem_req_rdy); end
        n_checks++; if (bus.transducer_l15_val !== 1'b0) begin n_errors++; $display("FAIL reset_l15_val: got %0h, expected 0", bus.transducer_l15_val); end
        n_checks++; if (bus.transducer_l15_req_ack !== 1'b0) begin n_errors++; $display("FAIL reset_req_ack: got %0h, expected 0", bus.transducer_l15_req_ack); end
        n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %0h, expected 0", err_timeout); end
        n_checks++; if (state_dbg !== S_IDLE) begin n_errors++; $display("FAIL reset_state: got %0h, expected %0h", state_dbg, S_IDLE); end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (state_dbg !== S_IDLE) begin n_errors++; $display("FAIL reset_release_state: got %0h, expected %0h", state_dbg, S_IDLE); end
    endtask

    task automatic test_mem_load;
        @(negedge clk);
        drive_mem(1'b0, 40'h00_0000_1000, 64'd0, 3'b011, 1'b0);
        #1;
        n_checks++; if (bus.mem_req_rdy !== 1'b1) begin n_errors++; $display("FAIL mem_load_rdy: got %0h, expected 1", bus.mem_req_rdy); end
        n_checks++; if (bus.io_req_rdy !== 1'b0) begin n_errors++; $display("FAIL mem_load_io_rdy: got %0h, expected 0", bus.io_req_rdy); end
        @(negedge clk);
        bus.mem_req_val = 1'b0;
        #1;
        n_checks++; if (state_dbg !== S_ISSUE) begin n_errors++; $display("FAIL mem_load_issue: got %0h, expected %0h", state_dbg, S_ISSUE); end
        n_checks++; if (bus.transducer_l15_val !== 1'b1) begin n_errors++; $display("FAIL mem_load_l15_val: got %0h, expected 1", bus.transducer_l15_val); end
        n_checks++; if (bus.transducer_l15_address !== 40'h00_0000_1000) begin n_errors++; $display("FAIL mem_load_addr: got %h, expected 0000001000", bus.transducer_l15_address); end
        n_checks++; if (bus.transducer_l15_rqtype !== LOAD_RQ) begin n_errors++; $display("FAIL mem_load_rqtype: got %0h, expected %0h", bus.transducer_l15_rqtype, LOAD_RQ); end
        n_checks++; if (bus.transducer_l15_size !== 3'b011) begin n_errors++; $display("FAIL mem_load_size: got %0h, expected 3", bus.transducer_l15_size); end
        n_checks++; if (bus.transducer_l15_nc !== 1'b0) begin n_errors++; $display("FAIL mem_load_nc: got %0h, expected 0", bus.transducer_l15_nc); end
        // L1.5 sits on the request for three cycles before accepting it
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.transducer_l15_val !== 1'b1 || bus.transducer_l15_address !== 40'h00_0000_1000) begin n_errors++; $display("FAIL mem_load_hold: got val=%0h addr=%h, expected val=1 addr=0000001000", bus.transducer_l15_val, bus.transducer_l15_address); end
        bus.l15_transducer_ack = 1'b1;
        @(negedge clk);
        bus.l15_transducer_ack = 1'b0;
        #1;
        n_checks++; if (bus.transducer_l15_val !== 1'b0) begin n_errors++; $display("FAIL mem_load_val_drop: got %0h, expected 0", bus.transducer_l15_val); end
        n_checks++; if (state_dbg !== S_WAIT) begin n_errors++; $display("FAIL mem_load_wait: got %0h, expected %0h", state_dbg, S_WAIT); end
        repeat (2) @(negedge clk);
        drive_ret(LOAD_RET, 64'h1122_3344_5566_7788);
        #1;
        n_checks++; if (bus.mem_rsp_val !== 1'b1) begin n_errors++; $display("FAIL mem_load_rsp_val: got %0h, expected 1", bus.mem_rsp_val); end
        n_checks++; if (bus.mem_rsp_data !== 64'h1122_3344_5566_7788) begin n_errors++; $display("FAIL mem_load_rsp_data: got %h, expected 1122334455667788", bus.mem_rsp_data); end
        n_checks++; if (bus.transducer_l15_req_ack !== 1'b1) begin n_errors++; $display("FAIL mem_load_req_ack: got %0h, expected 1", bus.transducer_l15_req_ack); end
        n_checks++; if (bus.io_rsp_val !== 1'b0) begin n_errors++; $display("FAIL mem_load_io_rsp: got %0h, expected 0", bus.io_rsp_val); end
        @(negedge clk);
        bus.l15_transducer_val = 1'b0;
        #1;
        n_checks++; if (bus.mem_rsp_val !== 1'b0) begin n_errors++; $display("FAIL mem_load_rsp_pulse: got %0h, expected 0", bus.mem_rsp_val); end
        n_checks++; if (state_dbg !== S_IDLE) begin n_errors++; $display("FAIL mem_load_idle: got %0h, expected %0h", state_dbg, S_IDLE); end
    endtask

    task automatic test_io_in(input logic [15:0] addr, input logic [31:0] exp_data);
        logic [39:0] exp_addr;
        exp_addr = {24'hF0_0000, addr};
        @(negedge clk);
        drive_io(1'b0, addr, 32'd0, 3'b010);
        #1;
        n_checks++; if (bus.io_req_rdy !== 1'b1 || bus.mem_req_rdy !== 1'b0) begin n_errors++; $display("FAIL io_in_rdy: got io=%0h mem=%0h, expected io=1 mem=0", bus.io_req_rdy, bus.mem_req_rdy); end
        @(negedge clk);
        bus.io_req_val = 1'b0;
        #1;
        n_checks++; if (bus.transducer_l15_address !== exp_addr) begin n_errors++; $display("FAIL io_in_addr: got %h, expected %h", bus.transducer_l15_address, exp_addr); end
        n_checks++; if (bus.transducer_l15_nc !== 1'b1) begin n_errors++; $display("FAIL io_in_nc: got %0h, expected 1", bus.transducer_l15_nc); end
        n_checks++; if (bus.transducer_l15_rqtype !== LOAD_RQ) begin n_errors++; $display("FAIL io_in_rqtype: got %0h, expected %0h", bus.transducer_l15_rqtype, LOAD_RQ); end
        bus.l15_transducer_ack = 1'b1;
        @(negedge clk);
        bus.l15_transducer_ack = 1'b0;
        drive_ret(LOAD_RET, 64'hAAAA_AAAA_5555_5555);
        #1;
        n_checks++; if (bus.io_rsp_val !== 1'b1 || bus.mem_rsp_val !== 1'b0) begin n_errors++; $display("FAIL io_in_rsp_val: got io=%0h mem=%0h, expected io=1 mem=0", bus.io_rsp_val, bus.mem_rsp_val); end
        n_checks++; if (bus.io_rsp_data !== exp_data) begin n_errors++; $display("FAIL io_in_rsp_data: got %h, expected %h", bus.io_rsp_data, exp_data); end
        @(negedge clk);
        bus.l15_transducer_val = 1'b0;
        #1;
        n_checks++; if (state_dbg !== S_IDLE) begin n_errors++; $display("FAIL io_in_idle: got %0h, expected %0h", state_dbg, S_IDLE); end
    endtask

    task automatic test_io_out;
        @(negedge clk);
        drive_io(1'b1, 16'h0080, 32'hDEAD_BEEF, 3'b010);
        @(negedge clk);
        bus.io_req_val = 1'b0;
        #1;
        n_checks++; if (bus.transducer_l15_rqtype !== STORE_RQ) begin n_errors++; $display("FAIL io_out_rqtype: got %0h, expected %0h", bus.transducer_l15_rqtype, STORE_RQ); end
        n_checks++; if (bus.transducer_l15_data !== 64'hDEAD_BEEF_DEAD_BEEF) begin n_errors++; $display("FAIL io_out_data: got %h, expected deadbeefdeadbeef", bus.transducer_l15_data); end
        n_checks++; if (bus.transducer_l15_address !== 40'hF0_0000_0080) begin n_errors++; $display("FAIL io_out_addr: got %h, expected f000000080", bus.transducer_l15_address); end
        bus.l15_transducer_ack = 1'b1;
        @(negedge clk);
        bus.l15_transducer_ack = 1'b0;
        drive_ret(ST_ACK, 64'h1234_5678_9ABC_DEF0);
        #1;
        n_checks++; if (bus.io_rsp_val !== 1'b1) begin n_errors++; $display("FAIL io_out_rsp_val: got %0h, expected 1", bus.io_rsp_val); end
        n_checks++; if (bus.io_rsp_data !== 32'd0) begin n_errors++; $display("FAIL io_out_rsp_data: got %h, expected 00000000", bus.io_rsp_data); end
        @(negedge clk);
        bus.l15_transducer_val = 1'b0;
    endtask

    task automatic test_contention;
        logic [0:0] exp_g;
        logic [39:0] exp_addr;
        exp_q = {};
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        @(negedge clk);
        drive_mem(1'b0, 40'h00_0000_2000, 64'd0, 3'b011, 1'b0);
        drive_io(1'b0, 16'h0060, 32'd0, 3'b010);
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_g = exp_q.pop_front();
            exp_addr = exp_g[0] ? 40'hF0_0000_0060 : 40'h00_0000_2000;
            n_checks++; if (state_dbg !== S_IDLE) begin n_errors++; $display("FAIL contention_idle[%0d]: got %0h, expected %0h", i, state_dbg, S_IDLE); end
            n_checks++; if ({bus.mem_req_rdy, bus.io_req_rdy} !== {~exp_g[0], exp_g[0]}) begin n_errors++; $display("FAIL contention_grant[%0d]: got mem/io=%b%b, expected %b%b", i, bus.mem_req_rdy, bus.io_req_rdy, ~exp_g[0], exp_g[0]); end
            @(negedge clk);
            #1;
            n_checks++; if ({bus.mem_req_rdy, bus.io_req_rdy} !== 2'b00) begin n_errors++; $display("FAIL contention_issue_rdy[%0d]: got %b%b, expected 00", i, bus.mem_req_rdy, bus.io_req_rdy); end
            n_checks++; if (bus.transducer_l15_address !== exp_addr) begin n_errors++; $display("FAIL contention_addr[%0d]: got %h, expected %h", i, bus.transducer_l15_address, exp_addr); end
            bus.l15_transducer_ack = 1'b1;
            @(negedge clk);
            bus.l15_transducer_ack = 1'b0;
            if (i == 3) begin
                bus.mem_req_val = 1'b0;
                bus.io_req_val = 1'b0;
            end
            drive_ret(LOAD_RET, 64'h100 + 64'(i));
            #1;
            n_checks++; if (state_dbg !== S_WAIT || {bus.mem_req_rdy, bus.io_req_rdy} !== 2'b00) begin n_errors++; $display("FAIL contention_wait[%0d]: got state=%0h rdy=%b%b, expected state=2 rdy=00", i, state_dbg, bus.mem_req_rdy, bus.io_req_rdy); end
            n_checks++; if ({bus.mem_rsp_val, bus.io_rsp_val} !== {~exp_g[0], exp_g[0]}) begin n_errors++; $display("FAIL contention_rsp[%0d]: got mem/io=%b%b, expected %b%b", i, bus.mem_rsp_val, bus.io_rsp_val, ~exp_g[0], exp_g[0]); end
            @(negedge clk);
            bus.l15_transducer_val = 1'b0;
        end
        #1;
        n_checks++; if (exp_q.size() != 0 || state_dbg !== S_IDLE) begin n_errors++; $display("FAIL contention_end: got q=%0d state=%0h, expected q=0 state=0", exp_q.size(), state_dbg); end
    endtask

    task automatic test_same_cycle_store;
        @(negedge clk);
        drive_mem(1'b1, 40'h00_0000_3000, 64'hCAFE_F00D_1234_5678, 3'b011, 1'b1);
        #1;
        n_checks++; if (bus.mem_req_rdy !== 1'b1) begin n_errors++; $display("FAIL store_rdy: got %0h, expected 1", bus.mem_req_rdy); end
        @(negedge clk);
        bus.mem_req_val = 1'b0;
        #1;
        n_checks++; if (bus.transducer_l15_rqtype !== STORE_RQ || bus.transducer_l15_data !== 64'hCAFE_F00D_1234_5678 || bus.transducer_l15_nc !== 1'b1) begin n_errors++; $display("FAIL store_fields: got rq=%0h data=%h nc=%0h, expected rq=1 data=cafef00d12345678 nc=1", bus.transducer_l15_rqtype, bus.transducer_l15_data, bus.transducer_l15_nc); end
        bus.l15_transducer_ack = 1'b1;
        drive_ret(ST_ACK, 64'hFFFF_0000_FFFF_0000);
        #1;
        n_checks++; if (bus.mem_rsp_val !== 1'b1) begin n_errors++; $display("FAIL store_same_cycle_rsp: got %0h, expected 1", bus.mem_rsp_val); end
        n_checks++; if (bus.mem_rsp_data !== 64'd0) begin n_errors++; $display("FAIL store_rsp_data: got %h, expected 0", bus.mem_rsp_data); end
        n_checks++; if (bus.transducer_l15_req_ack !== 1'b1) begin n_errors++; $display("FAIL store_req_ack: got %0h, expected 1", bus.transducer_l15_req_ack); end
        @(negedge clk);
        bus.l15_transducer_ack = 1'b0;
        bus.l15_transducer_val = 1'b0;
        drive_io(1'b0, 16'h0070, 32'd0, 3'b010);
        #1;
        n_checks++; if (state_dbg !== S_IDLE || bus.transducer_l15_val !== 1'b0) begin n_errors++; $display("FAIL store_back_idle: got state=%0h val=%0h, expected state=0 val=0", state_dbg, bus.transducer_l15_val); end
        n_checks++; if (bus.io_req_rdy !== 1'b1) begin n_errors++; $display("FAIL store_next_rdy: got %0h, expected 1", bus.io_req_rdy); end
        @(negedge clk);
        bus.io_req_val = 1'b0;
        #1;
        n_checks++; if (state_dbg !== S_ISSUE) begin n_errors++; $display("FAIL store_next_issue: got %0h, expected %0h", state_dbg, S_ISSUE); end
        bus.l15_transducer_ack = 1'b1;
        @(negedge clk);
        bus.l15_transducer_ack = 1'b0;
        drive_ret(LOAD_RET, 64'h0);
        @(negedge clk);
        bus.l15_transducer_val = 1'b0;
    endtask

    task automatic test_int_ret;
        @(negedge clk);
        drive_mem(1'b0, 40'h00_0000_4000, 64'd0, 3'b011, 1'b0);
        @(negedge clk);
        bus.mem_req_val = 1'b0;
        bus.l15_transducer_ack = 1'b1;
        @(negedge clk);
        bus.l15_transducer_ack = 1'b0;
        drive_ret(INT_RET, 64'h5A5A_5A5A_5A5A_5A5A);
        #1;
        n_checks++; if (bus.transducer_l15_req_ack !== 1'b1) begin n_errors++; $display("FAIL int_ret_req_ack: got %0h, expected 1", bus.transducer_l15_req_ack); end
        n_checks++; if ({bus.mem_rsp_val, bus.io_rsp_val} !== 2'b00) begin n_errors++; $display("FAIL int_ret_no_rsp: got %b%b, expected 00", bus.mem_rsp_val, bus.io_rsp_val); end
        @(negedge clk);
        bus.l15_transducer_val = 1'b0;
        #1;
        n_checks++; if (state_dbg !== S_WAIT) begin n_errors++; $display("FAIL int_ret_stays_wait: got %0h, expected %0h", state_dbg, S_WAIT); end
        drive_ret(LOAD_RET, 64'h0102_0304_0506_0708);
        #1;
        n_checks++; if (bus.mem_rsp_val !== 1'b1 || bus.mem_rsp_data !== 64'h0102_0304_0506_0708) begin n_errors++; $display("FAIL int_ret_then_load: got val=%0h data=%h, expected val=1 data=0102030405060708", bus.mem_rsp_val, bus.mem_rsp_data); end
        @(negedge clk);
        bus.l15_transducer_val = 1'b0;
        #1;
        n_checks++; if (state_dbg !== S_IDLE) begin n_errors++; $display("FAIL int_ret_idle: got %0h, expected %0h", state_dbg, S_IDLE); end
    endtask

    task automatic test_timeout;
        @(negedge clk);
        drive_io(1'b0, 16'h0010, 32'd0, 3'b010);
        @(negedge clk);
        bus.io_req_val = 1'b0;
        bus.l15_transducer_ack = 1'b1;
        @(negedge clk);
        bus.l15_transducer_ack = 1'b0;
        #1;
        n_checks++; if (state_dbg !== S_WAIT || err_timeout !== 1'b0) begin n_errors++; $display("FAIL timeout_enter: got state=%0h err=%0h, expected state=2 err=0", state_dbg, err_timeout); end
        // first 15 WAIT cycles stay quiet, the 16th aborts
        for (int i = 0; i < 15; i++) begin
            n_checks++; if (bus.io_rsp_val !== 1'b0 || state_dbg !== S_WAIT) begin n_errors++; $display("FAIL timeout_early[%0d]: got rsp=%0h state=%0h, expected rsp=0 state=2", i, bus.io_rsp_val, state_dbg); end
            @(negedge clk);
            #1;
        end
        n_checks++; if (bus.io_rsp_val !== 1'b1 || bus.mem_rsp_val !== 1'b0) begin n_errors++; $display("FAIL timeout_rsp_val: got io=%0h mem=%0h, expected io=1 mem=0", bus.io_rsp_val, bus.mem_rsp_val); end
        n_checks++; if (bus.io_rsp_data !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL timeout_rsp_data: got %h, expected ffffffff", bus.io_rsp_data); end
        @(negedge clk);
        #1;
        n_checks++; if (state_dbg !== S_IDLE || err_timeout !== 1'b1) begin n_errors++; $display("FAIL timeout_abort: got state=%0h err=%0h, expected state=0 err=1", state_dbg, err_timeout); end
        drive_ret(LOAD_RET, 64'h7777_7777_7777_7777);
        #1;
        n_checks++; if (bus.transducer_l15_req_ack !== 1'b1 || {bus.mem_rsp_val, bus.io_rsp_val} !== 2'b00) begin n_errors++; $display("FAIL timeout_stale: got ack=%0h rsp=%b%b, expected ack=1 rsp=00", bus.transducer_l15_req_ack, bus.mem_rsp_val, bus.io_rsp_val); end
        @(negedge clk);
        bus.l15_transducer_val = 1'b0;
        #1;
        n_checks++; if (state_dbg !== S_IDLE || err_timeout !== 1'b1) begin n_errors++; $display("FAIL timeout_sticky: got state=%0h err=%0h, expected state=0 err=1", state_dbg, err_timeout); end
    endtask

    task automatic test_reset_mid_issue;
        @(negedge clk);
        drive_mem(1'b0, 40'h00_0000_5000, 64'd0, 3'b011, 1'b0);
        @(negedge clk);
        bus.mem_req_val = 1'b0;
        #1;
        n_checks++; if (bus.transducer_l15_val !== 1'b1) begin n_errors++; $display("FAIL rst_issue_pre: got %0h, expected 1", bus.transducer_l15_val); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.transducer_l15_val !== 1'b0) begin n_errors++; $display("FAIL rst_issue_val: got %0h, expected 0", bus.transducer_l15_val); end
        n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL rst_issue_err: got %0h, expected 0", err_timeout); end
        n_checks++; if (state_dbg !== S_IDLE || bus.transducer_l15_address !== 40'd0) begin n_errors++; $display("FAIL rst_issue_state: got state=%0h addr=%h, expected state=0 addr=0", state_dbg, bus.transducer_l15_address); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (state_dbg !== S_IDLE || bus.transducer_l15_val !== 1'b0) begin n_errors++; $display("FAIL rst_issue_release: got state=%0h val=%0h, expected state=0 val=0", state_dbg, bus.transducer_l15_val); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_mem_load();
        test_io_in(16'h03F8, 32'hAAAA_AAAA);
        test_io_in(16'h03FC, 32'h5555_5555);
        test_io_out();
        test_contention();
        test_same_cycle_store();
        test_int_ret();
        test_timeout();
        test_reset_mid_issue();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
